// File: rtl/cdec8_dbg_scan.sv
// Debug scanner: on trig walks resad 0x00-0x0F (2 cycles each), then sends A5, 16 bytes, checksum as UART 8N1.
// Latency trig->first start bit 33 cycles; no backpressure (trig ignored while busy, auto re-arms at frame end).
module cdec8_dbg_scan #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       trig,
  input  logic       auto,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  input  logic [7:0] ext_state,
  input  logic [7:0] ext_signal,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;

  state_t          state, state_nxt;
  logic [4:0]      cnt;
  logic [15:0][7:0] snap;
  logic [7:0]      csum;
  logic [BW-1:0]   baud;
  logic [3:0]      bitn;
  logic [4:0]      byten;
  logic [7:0]      sel_dat;
  logic [7:0]      cur_byte;
  logic            cap_last;
  logic            tx_end;

  // 0x0B/0x0C are not driven on the bus, so resdt is never taken there
  always_comb begin
    sel_dat = resdt;
    if (cnt[4:1] == 4'hB)
      sel_dat = ext_state;
    else if (cnt[4:1] == 4'hC)
      sel_dat = ext_signal;
  end

  always_comb begin
    cur_byte = snap[4'(byten - 5'd1)];
    if (byten == 5'd0)
      cur_byte = 8'hA5;
    else if (byten == 5'd17)
      cur_byte = csum;
  end

  always_comb begin
    state_nxt = state;
    cap_last  = (cnt == 5'd31);
    tx_end    = (baud == BAUD_LAST) && (bitn == 4'd9) && (byten == 5'd17);
    case (state)
      IDLE:    if (trig) state_nxt = CAPTURE;
      CAPTURE: if (cap_last) state_nxt = SEND;
      SEND:    if (tx_end) state_nxt = DONE;
      DONE:    state_nxt = auto ? CAPTURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      cnt   <= '0;
      snap  <= '0;
      csum  <= '0;
      baud  <= '0;
      bitn  <= '0;
      byten <= '0;
      txd   <= 1'b1;
    end else begin
      case (state)
        CAPTURE: begin
          cnt <= cnt + 5'd1;
          if (cnt[0]) begin
            snap[cnt[4:1]] <= sel_dat;
            csum           <= csum + sel_dat;
          end
          if (cap_last) begin
            txd   <= 1'b0;
            baud  <= '0;
            bitn  <= '0;
            byten <= '0;
          end
        end
        SEND: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bitn == 4'd9) begin
              bitn <= '0;
              if (byten == 5'd17) begin
                txd <= 1'b1;
              end else begin
                byten <= byten + 5'd1;
                txd   <= 1'b0;
              end
            end else begin
              bitn <= bitn + 4'd1;
              txd  <= (bitn == 4'd8) ? 1'b1 : cur_byte[bitn[2:0]];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          cnt  <= '0;
          csum <= '0;
          txd  <= 1'b1;
        end
      endcase
    end
  end

  assign resad      = (state == CAPTURE) ? {4'h0, cnt[4:1]} : 8'h00;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: doc/cdec8_dbg_scan.md
# cdec8_dbg_scan

Debug-monitor scanner for the CDEC8 datapath: the master end of the resource observation bus (`resad`/`resdt`). On a trigger it walks resource addresses 0x00–0x0F and captures one snapshot byte per address. It then streams the snapshot to the host PC as a framed UART 8N1 byte sequence: sync byte, 16 data bytes, checksum. It sits in the FPGA top level between the datapath's debug bus and the board UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `clock`  in  1  system clock, rising edge.
- `reset_N`  in  1  asynchronous, active-low reset.
- `trig`  in  1  starts one frame; sampled only in IDLE.
- `auto`  in  1  when 1, a new frame starts automatically after each frame completes.
- `resad`  out  8  resource address driven to the datapath.
- `resdt`  in  8  resource data returned by the datapath.
- `ext_state`  in  8  substituted for address 0x0B; this address is not driven by the datapath.
- `ext_signal`  in  8  substituted for address 0x0C; this address is not driven by the datapath.
- `txd`  out  1  UART serial out; idle high.
- `busy`  out  1  high from frame start until frame end.
- `frame_done`  out  1  one-cycle pulse when the checksum stop bit completes.

## Operation
- States:
  - IDLE: `trig=1` goes to CAPTURE.
  - CAPTURE: goes to SEND after 16 addresses.
  - SEND: transmits 18 bytes.
  - DONE: one cycle.
    - If `auto=1`, goes to CAPTURE.
    - Otherwise goes to IDLE.
- CAPTURE:
  - Address n (0..15) is held on `resad` for 2 cycles, so the datapath mux can settle.
  - The captured byte is latched into buffer[n] on the second edge.
  - n=0x0B latches `ext_state`; n=0x0C latches `ext_signal`; all other addresses latch `resdt`.
  - `resdt` is never sampled at 0x0B or 0x0C, because the bus is undriven there.
- `resad` = 0x00 outside CAPTURE.
- Checksum = (buffer[0] + … + buffer[15]) mod 256, computed at 8 bits with the carry discarded. It is accumulated during CAPTURE.
- Frame byte order: 0xA5, buffer[0] … buffer[15], checksum (18 bytes).
- Byte format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - There is no idle gap between bytes; the next start bit follows the stop bit directly.
- `trig` during `busy` is ignored; it is not queued.
- `auto` is sampled only in DONE. Deasserting `auto` mid-frame lets the current frame finish and then returns to IDLE.

## Timing
- Reset values:
  - `txd`=1, `busy`=0, `frame_done`=0, `resad`=0x00.
  - State = IDLE; buffer and checksum = 0.
  - Reset takes effect asynchronously: `txd` returns high immediately, even mid-bit.
- Let edge E0 be the edge that samples `trig=1` in IDLE. After E0: `busy`=1 and `resad`=0x00.
- Capture timing:
  - `resad`=n is valid after edge E(2n), for n ≥ 1.
  - buffer[n] is latched at edge E(2n+2).
  - The last latch (n=15) is at E32.
- After E32: `txd`=0 (start bit of 0xA5) and `resad`=0x00.
- Each byte occupies 10·`CLKS_PER_BIT` cycles.
- Stop bit of the checksum byte:
  - It ends at edge E(32 + 180·`CLKS_PER_BIT`).
  - After that edge: DONE, `frame_done`=1 for one cycle, `txd`=1.
- After the following edge:
  - If `auto=0`: `busy`=0 and state IDLE. A new `trig` is accepted on that edge at the earliest.
  - If `auto=1`: `busy` stays 1 and the next frame's E0 is the DONE edge.
- Latency from `trig` to the first `txd` falling edge = 33 cycles.
- The capture snapshot is not atomic; the 32-cycle window is the accepted skew.

## Test plan
- Single frame:
  - Setup: `CLKS_PER_BIT`=4; datapath model returns `resdt`=0x10+`resad`; `ext_state`=0x1B, `ext_signal`=0x1C; pulse `trig`.
  - Required: decoded bytes A5, 10..1F, 78.
  - Required: first start bit exactly 33 cycles after `trig`; `frame_done` pulse at E752; `busy` low at E753.
- Substitution and wrap:
  - Setup: same as the single-frame case, but `ext_state`=0xFF, `ext_signal`=0x01.
  - Required: bytes 11 and 12 are FF and 01; checksum 0x41 (mod-256 wrap).
  - Required: `resad` never equals 0x0B or 0x0C on a `resdt` latch edge.
- Bit timing:
  - Setup: `CLKS_PER_BIT`=7.
  - Required: every `txd` bit is exactly 7 cycles; no gap between bytes; `txd`=1 throughout IDLE.
- Trigger during busy:
  - Setup: pulse `trig` at cycle 100 of a frame.
  - Required: the frame is unaltered; exactly one `frame_done`; the FSM returns to IDLE.
- Auto mode:
  - Setup: `auto`=1 for two frames, then `auto`=0.
  - Required: back-to-back frames with `busy` continuously 1; the second frame's first start bit comes 33 cycles after the first frame's `frame_done`; IDLE after the third frame.
- Reset mid-frame:
  - Setup: assert `reset_N`=0 during a data bit with `txd`=0.
  - Required: `txd`=1, `busy`=0, `resad`=0x00 immediately, without waiting for a clock edge.
  - Required: after release, a `trig` produces a full, correct frame.
